instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//  Issues instructions to the l3 datapath/control state machine, replacing the hand-timed bench stimulus.
//  Holds a small loadable program memory.
//  Drives instr[0:10] and exec with per-opcode hold windows and idle gaps.
//  Sits between the board/bench and l3_SM; the l3 datapath is unchanged.
// PARAMETERS
//  DEPTH       16  program words (power of 2)
//  AW          4   address width, log2(DEPTH)
//  HOLD_LD     3   exec-high cycles for opcode 000 (load)
//  HOLD_OP     5   exec-high cycles for every other opcode
//  GAP         1   exec-low cycles between instructions (>=1)
// PORTS
//  clk        in   1     rising-edge clock
//  rst        in   1     synchronous, active-high reset
//  prog_we    in   1     program write strobe (honoured only when busy=0)
//  prog_addr  in   AW    program write address
//  prog_data  in   11    instruction word, bit 0 = opcode MSB
//  prog_len   in   AW+1  instructions to run, 0..DEPTH
//  start      in   1     begin run at pc=0 (sampled in IDLE/DONE only)
//  abort      in   1     terminate run
//  instr      out  [0:10]  opcode[0:2] reg_x[3:4] reg_y[5:6] imm[7:10]
//  exec       out  1     instruction-valid level to l3_SM
//  pc         out  AW    index of instruction being issued
//  busy       out  1     run in progress
//  done       out  1     run completed; held until next start/rst
// BEHAVIOUR
//  - Outputs are registered. Reset values: instr=0, exec=0, pc=0, busy=0, done=0; state IDLE.
//    Program memory is not cleared by rst.
//  - States: IDLE, ISSUE, GAP, DONE.
//  - IDLE/DONE, start=1, prog_len!=0: next cycle -> ISSUE with pc=0, instr=mem[0], exec=1, busy=1, done=0.
//  - IDLE/DONE, start=1, prog_len==0: -> DONE directly, done=1; exec never asserts.
//  - ISSUE: exec=1 and instr stable for exactly HOLD_LD cycles (opcode 000) or HOLD_OP cycles (all others).
//    Count is loaded on entry. Then -> GAP.
//  - GAP: exec=0 for exactly GAP cycles; instr holds its last value.
//    At GAP end: if pc==prog_len-1 -> DONE (busy=0, done=1);
//    else pc<=pc+1 and -> ISSUE with instr=mem[pc+1].
//  - prog_len is latched at start; changes during a run are ignored.
//  - pc never wraps: the run ends at pc=prog_len-1. prog_len>DEPTH is saturated to DEPTH.
//  - prog_we while busy=1 is ignored, so memory is unchanged.
//    prog_we with start in the same IDLE cycle: the write lands first; the run reads the new word.
//  - abort (any state): next cycle exec=0, busy=0, done=0, state IDLE, pc=0.
//    abort has priority over start.
//  - rst mid-run: identical to abort, plus instr=0. rst has priority over everything.
//  - Period per instruction = hold + GAP. With defaults: load = 4 cycles, others = 6 cycles.
// STRUCTURE
//  - Shared header l3_defs.vh: opcode constants OP_LOAD=000, OP_MOV=001, OP_SUB=010, OP_ADD=011,
//    OP_DISP=100, OP_SUBI=110, OP_ADDI=111; field position defines; default HOLD_* values.
//  - One sub-module, prog_mem: DEPTH x 11 RAM, synchronous write, asynchronous read.
//  - FSM, hold/gap counter, and pc live in instr_sequencer.
// TESTING
//  1. rst, load program {00000000001, 00001000010}, prog_len=2, start
//     -> exec high 3 cycles with instr=00000000001, low 1, high 3 with 00001000010, low 1; then done=1.
//  2. Full l3 program (4 loads, mov r2<-r3, add, sub, addi 5, subi 2, disp), DUT driving l3_SM
//     -> final r3=10; DP latch=10; exec hold of 5 for non-load opcodes.
//  3. abort during the 3rd cycle of an add instruction -> next cycle exec=0, busy=0, pc=0;
//     a following start reissues mem[0].
//  4. prog_len=0 with start -> done=1 one cycle later; exec stays 0.
//  5. prog_we to addr 1 while busy -> mem[1] unchanged on readback.
//     prog_we together with start in IDLE -> new word issued.
//  6. prog_len=DEPTH, all 16 words -> pc reaches 15, no wrap, done=1.
//     rst mid-run -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the l3 instruction sequencer:
// opcodes, instruction field layout, default timing and FSM states.
package instr_sequencer_pkg;

  localparam int IW          = 11;
  localparam int DEPTH_DEF   = 16;
  localparam int AW_DEF      = 4;
  localparam int HOLD_LD_DEF = 3;
  localparam int HOLD_OP_DEF = 5;
  localparam int GAP_DEF     = 1;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_DISP = 3'b100;
  localparam logic [2:0] OP_SUBI = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  // Field positions within instr[0:10]; bit 0 is the opcode MSB
  localparam int F_OP_HI  = 0;
  localparam int F_OP_LO  = 2;
  localparam int F_RX_HI  = 3;
  localparam int F_RX_LO  = 4;
  localparam int F_RY_HI  = 5;
  localparam int F_RY_LO  = 6;
  localparam int F_IMM_HI = 7;
  localparam int F_IMM_LO = 10;

  typedef logic [0:IW-1] word_t;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic logic is_load(input word_t w);
    return w[F_OP_HI:F_OP_LO] == OP_LOAD;
  endfunction

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: DEPTH x 11 words, synchronous write,
// asynchronous read. Not cleared by reset.
module prog_mem
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  logic [AW-1:0] raddr,
  output word_t         rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Issues the stored program to l3_SM as instr/exec pulses
// with per-opcode hold windows and idle gaps.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int AW      = AW_DEF,
  parameter int HOLD_LD = HOLD_LD_DEF,
  parameter int HOLD_OP = HOLD_OP_DEF,
  parameter int GAP     = GAP_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [0:10]   prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          abort,
  output logic [0:10]   instr,
  output logic          exec,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  localparam int HMAX = (HOLD_LD > HOLD_OP) ? HOLD_LD : HOLD_OP;
  localparam int CMAX = (HMAX > GAP) ? HMAX : GAP;
  localparam int CW   = $clog2(CMAX + 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [AW:0]   len_q;
  logic [AW:0]   len_sat;
  logic [AW-1:0] rd_addr;
  logic          mem_we;
  logic          last;
  word_t         rd_word;
  word_t         next_word;

  function automatic logic [CW-1:0] hold_cnt(input word_t w);
    return is_load(w) ? CW'(HOLD_LD - 1) : CW'(HOLD_OP - 1);
  endfunction

  assign mem_we  = prog_we & ~busy;
  assign rd_addr = (state == S_GAP) ? pc + 1'b1 : '0;
  assign len_sat = (prog_len > (AW+1)'(DEPTH)) ?
                   (AW+1)'(DEPTH) : prog_len;
  assign last    = ({1'b0, pc} == len_q - 1'b1);

  // A write landing with start must be seen by the first issue
  assign next_word = (mem_we && prog_addr == rd_addr) ?
                     prog_data : rd_word;

  prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      len_q <= '0;
      instr <= '0;
      exec  <= 1'b0;
      pc    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
      exec  <= 1'b0;
      pc    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            len_q <= len_sat;
            pc    <= '0;
            if (len_sat != '0) begin
              state <= S_ISSUE;
              instr <= next_word;
              exec  <= 1'b1;
              busy  <= 1'b1;
              done  <= 1'b0;
              cnt   <= hold_cnt(next_word);
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (cnt == '0) begin
            state <= S_GAP;
            exec  <= 1'b0;
            cnt   <= CW'(GAP - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_ISSUE;
            pc    <= pc + 1'b1;
            instr <= next_word;
            exec  <= 1'b1;
            cnt   <= hold_cnt(next_word);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
